tone_driver: RTL
================

Name: tone_driver

Overview:
- Downstream stage of the free-play/record-playback block. Consumes its two note/octave streams: live keys (channel 1) and recording playback (channel 2).
- Selects one channel and converts the 4-bit note plus 2-bit octave into a square-wave buzzer drive.
- Inserts a short silent articulation gap between consecutive different notes, so repeated melodies are audible as separate notes.
- Sits between the mode logic and the buzzer pin.

Parameters:
- CNT_W, 20: width of the half-period down-counter. Must hold the largest half-period, 382220.
- GAP_CYCLES, 1000000: silent cycles inserted between two different sounding notes (10 ms at 100 MHz). Must be ≥1.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  0 forces silence.
- play_active  in  1  1 selects channel 2 (playback), 0 selects channel 1 (live).
- note_in1  in  4  live note: 0 = rest, 1..7 = do..si.
- octave_in1  in  2  live octave.
- note_in2  in  4  playback note, same encoding as note_in1.
- octave_in2  in  2  playback octave.
- buzzer  out  1  square-wave drive.
- note_active  out  1  high while in TONE.
- cur_note  out  4  note currently sounding; 0 when not in TONE.
- cur_octave  out  2  octave currently sounding; 0 when not in TONE.

Behaviour:
- Reset, applied at any time including mid-tone or mid-gap:
  - state=IDLE; buzzer, note_active, cur_note, cur_octave all 0.
  - Counters and input registers cleared.
  - All outputs 0 on the cycle after reset is sampled high.
- Input stage:
  - Each cycle, register sel_note/sel_oct from channel 2 if play_active, else channel 1.
  - Note values 0 and 8..15 are rest.
  - Octave 2'b11 is treated as 2'b10.
- Half-period table (mid octave, 100 MHz):
  - 1=191110, 2=170265, 3=151685, 4=143172, 5=127551, 6=113636, 7=101239.
  - Octave 00 (low): value<<1. Octave 01: value. Octave 10/11 (high): value>>1.
  - The table is combinational from sel_note/sel_oct.
- FSM states: IDLE, TONE, GAP.
- IDLE:
  - buzzer=0, note_active=0.
  - If enable and sel_note is not rest: next edge → TONE. cur_note/cur_octave ← sel; half_cnt ← half-1; buzzer ← 1; note_active ← 1.
  - Latency: buzzer rises on the 2nd rising edge after the input change (1 input-register cycle + 1 FSM cycle).
- TONE:
  - Each cycle half_cnt decrements. At 0: buzzer toggles and half_cnt ← half-1.
  - Buzzer period is exactly 2*half cycles at 50% duty.
  - If sel_note/sel_oct differ from cur_note/cur_octave and sel is not rest: → GAP. buzzer ← 0, note_active ← 0, cur_note/cur_octave ← 0, gap_cnt ← GAP_CYCLES-1.
  - If sel becomes rest: → IDLE immediately, buzzer ← 0, no gap.
  - Same note held: tone continues uninterrupted, with no phase reset.
- GAP:
  - buzzer=0. gap_cnt decrements.
  - Input changes during GAP do not restart it.
  - When gap_cnt=0, sample sel at that edge: not rest → TONE with the freshly loaded half (buzzer ← 1); rest → IDLE.
- enable=0 in any state: next edge → IDLE, all outputs 0. enable has priority over input changes; reset has priority over everything.
- play_active toggling is treated exactly like a note change on the selected value. Equal values on both channels cause no gap.
- Counters never wrap. Half values are below 2^CNT_W.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, channel-1 note 5 present → buzzer, note_active, cur_note, cur_octave all 0 until 2 edges after reset drops; then cur_note=5, cur_octave=1.
- Mid A (note6, octave1, enable=1): buzzer rises 2 edges after input; high 113636 cycles, low 113636, period 227272; note_active=1.
- Octave scaling: note1 octave0 → half 382220. Note7 octave2 → half 50619. Note7 octave3 → half 50619.
- Note change with GAP_CYCLES=8: note3 → note4 mid-tone → buzzer 0 for exactly 8 cycles, then new tone with half 143172. Change to note5 inside the gap → tone at the end of the gap uses note5 (127551).
- Rest and enable: note 0 mid-tone → buzzer 0 the next edge, IDLE, no gap. enable=0 mid-gap → IDLE. Note 9 from IDLE → stays silent.
- Channel select and mid-op reset: live note2, playback note6, play_active 0→1 → gap then half 113636. Reset asserted mid-tone → all outputs 0 next edge.

Source files
------------

// File: rtl/tone_driver.sv
// ---------------------------------------------------------------------------
// tone_driver
//   Picks the live (channel 1) or playback (channel 2) note/octave stream and
//   turns it into a 50% duty square wave for the buzzer. A silent gap is put
//   between two different sounding notes, so repeated melodies stay audible
//   as separate notes.
//
// Ports
//   clk          in   system clock (100 MHz)
//   reset        in   synchronous, active-high reset
//   enable       in   0 forces silence
//   play_active  in   1 selects channel 2 (playback), 0 selects channel 1 (live)
//   note_in1     in   live note, 0 = rest, 1..7 = do..si, 8..15 = rest
//   octave_in1   in   live octave (2'b11 behaves as 2'b10)
//   note_in2     in   playback note, same encoding
//   octave_in2   in   playback octave
//   buzzer       out  square-wave drive
//   note_active  out  high while a tone is sounding
//   cur_note     out  note currently sounding, 0 otherwise
//   cur_octave   out  octave currently sounding, 0 otherwise
// ---------------------------------------------------------------------------
module tone_driver #(
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned GAP_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       play_active,
    input  logic [3:0] note_in1,
    input  logic [1:0] octave_in1,
    input  logic [3:0] note_in2,
    input  logic [1:0] octave_in2,
    output logic       buzzer,
    output logic       note_active,
    output logic [3:0] cur_note,
    output logic [1:0] cur_octave
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StTone, StGap} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_sel_note;
    logic [1:0]       r_sel_oct;
    logic [3:0]       r_cur_note;
    logic [3:0]       w_cur_note_next;
    logic [1:0]       r_cur_oct;
    logic [1:0]       w_cur_oct_next;
    logic             r_buzzer;
    logic             w_buzzer_next;
    logic [CNT_W-1:0] r_half_cnt;
    logic [CNT_W-1:0] w_half_cnt_next;
    logic [GapW-1:0]  r_gap_cnt;
    logic [GapW-1:0]  w_gap_cnt_next;

    logic [3:0]       w_in_note;
    logic [1:0]       w_in_oct;
    logic [3:0]       w_in_note_norm;
    logic [1:0]       w_in_oct_norm;
    logic [CNT_W-1:0] w_half_mid;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_half_m1;
    logic             w_sel_rest;
    logic             w_sel_diff;

    // Channel select and normalisation: out-of-range notes collapse to rest (0)
    // and octave 3 collapses to 2, so later comparisons see canonical values.
    always_comb begin
        w_in_note      = play_active ? note_in2 : note_in1;
        w_in_oct       = play_active ? octave_in2 : octave_in1;
        w_in_note_norm = (w_in_note >= 4'd1 && w_in_note <= 4'd7) ? w_in_note : 4'd0;
        w_in_oct_norm  = (w_in_oct == 2'b11) ? 2'b10 : w_in_oct;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_note <= 4'd0;
            r_sel_oct  <= 2'd0;
        end else begin
            r_sel_note <= w_in_note_norm;
            r_sel_oct  <= w_in_oct_norm;
        end
    end

    // Half-period in clock cycles for the middle octave at 100 MHz.
    always_comb begin
        case (r_sel_note)
            4'd1:    w_half_mid = CNT_W'(191110);
            4'd2:    w_half_mid = CNT_W'(170265);
            4'd3:    w_half_mid = CNT_W'(151685);
            4'd4:    w_half_mid = CNT_W'(143172);
            4'd5:    w_half_mid = CNT_W'(127551);
            4'd6:    w_half_mid = CNT_W'(113636);
            4'd7:    w_half_mid = CNT_W'(101239);
            default: w_half_mid = '0;
        endcase
        case (r_sel_oct)
            2'b00:   w_half = w_half_mid << 1;
            2'b01:   w_half = w_half_mid;
            default: w_half = w_half_mid >> 1;
        endcase
        w_half_m1  = w_half - CNT_W'(1);
        w_sel_rest = (r_sel_note == 4'd0);
        w_sel_diff = (r_sel_note != r_cur_note) || (r_sel_oct != r_cur_oct);
    end

    always_comb begin
        w_state_next    = r_state;
        w_cur_note_next = r_cur_note;
        w_cur_oct_next  = r_cur_oct;
        w_buzzer_next   = r_buzzer;
        w_half_cnt_next = r_half_cnt;
        w_gap_cnt_next  = r_gap_cnt;

        if (!enable) begin
            w_state_next    = StIdle;
            w_cur_note_next = 4'd0;
            w_cur_oct_next  = 2'd0;
            w_buzzer_next   = 1'b0;
            w_half_cnt_next = '0;
            w_gap_cnt_next  = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_buzzer_next = 1'b0;
                    if (!w_sel_rest) begin
                        w_state_next    = StTone;
                        w_cur_note_next = r_sel_note;
                        w_cur_oct_next  = r_sel_oct;
                        w_half_cnt_next = w_half_m1;
                        w_buzzer_next   = 1'b1;
                    end
                end
                StTone: begin
                    if (w_sel_rest) begin
                        // Rest ends the tone immediately; no articulation gap.
                        w_state_next    = StIdle;
                        w_cur_note_next = 4'd0;
                        w_cur_oct_next  = 2'd0;
                        w_buzzer_next   = 1'b0;
                        w_half_cnt_next = '0;
                    end else if (w_sel_diff) begin
                        w_state_next    = StGap;
                        w_cur_note_next = 4'd0;
                        w_cur_oct_next  = 2'd0;
                        w_buzzer_next   = 1'b0;
                        w_half_cnt_next = '0;
                        w_gap_cnt_next  = GapW'(GAP_CYCLES - 1);
                    end else if (r_half_cnt == '0) begin
                        w_buzzer_next   = ~r_buzzer;
                        w_half_cnt_next = w_half_m1;
                    end else begin
                        w_half_cnt_next = r_half_cnt - CNT_W'(1);
                    end
                end
                StGap: begin
                    w_buzzer_next = 1'b0;
                    if (r_gap_cnt == '0) begin
                        // Selection is sampled only here, so changes made during
                        // the gap pick the next note without restarting the gap.
                        if (!w_sel_rest) begin
                            w_state_next    = StTone;
                            w_cur_note_next = r_sel_note;
                            w_cur_oct_next  = r_sel_oct;
                            w_half_cnt_next = w_half_m1;
                            w_buzzer_next   = 1'b1;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end else begin
                        w_gap_cnt_next = r_gap_cnt - GapW'(1);
                    end
                end
                default: begin
                    w_state_next    = StIdle;
                    w_cur_note_next = 4'd0;
                    w_cur_oct_next  = 2'd0;
                    w_buzzer_next   = 1'b0;
                    w_half_cnt_next = '0;
                    w_gap_cnt_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cur_note <= 4'd0;
            r_cur_oct  <= 2'd0;
            r_buzzer   <= 1'b0;
            r_half_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cur_note <= w_cur_note_next;
            r_cur_oct  <= w_cur_oct_next;
            r_buzzer   <= w_buzzer_next;
            r_half_cnt <= w_half_cnt_next;
            r_gap_cnt  <= w_gap_cnt_next;
        end
    end

    assign buzzer      = r_buzzer;
    assign note_active = (r_state == StTone);
    assign cur_note    = r_cur_note;
    assign cur_octave  = r_cur_oct;

endmodule
